hist_bin_updater: RTL and testbench
===================================

Name: hist_bin_updater

Overview:
- Read-modify-write histogram engine that sits directly upstream of the histogram RAM (single-port, 1-cycle read latency).
- Accepts a stream of raw samples, maps each sample to a bin index, reads that bin, increments it and writes it back.
- Also provides a hardware sweep that clears every bin to 0.
- Its RAM-side outputs feed the RAM address/data/wren mux, which the top level selects when the regfile JTAG override bit is clear.

Parameters:
ADDR_W, 12, bin address width; 2^ADDR_W bins
DATA_W, 32, bin counter width
SAMPLE_W, 16, input sample width
BIN_SHIFT, 4, right shift applied to a sample to form its bin index

Ports:
clock  input  1  single clock, rising-edge
ctrl_reset  input  1  asynchronous, active-high reset
clear_start  input  1  one-cycle pulse; starts the clear sweep
clear_busy  output  1  high while the clear sweep runs
s_valid  input  1  sample valid
s_ready  output  1  sample accepted when s_valid & s_ready at a clock edge
s_data  input  SAMPLE_W  raw sample
ram_address  output  ADDR_W  RAM address
ram_data  output  DATA_W  RAM write data
ram_wren  output  1  RAM write enable, one cycle per write
ram_q  input  DATA_W  RAM read data; valid the cycle after the address is presented
sample_count  output  32  samples committed since the last clear or reset
sat_flag  output  1  sticky "a bin hit its maximum" flag (see Optional Feature)

Behaviour:
- Reset values: state IDLE; ram_address=0, ram_data=0, ram_wren=0, clear_busy=0, sample_count=0, sat_flag=0, all internal registers 0. RAM contents are not touched.
- s_ready = (state==IDLE) & ~clear_start. It is combinational; no other output is combinational.
- Bin mapping: idx = s_data >> BIN_SHIFT. If idx > 2^ADDR_W-1, the bin is 2^ADDR_W-1 (clamp, no wrap). The bin is latched at accept.
- State machine, one sample per 4 cycles:
  - IDLE:
    - If clear_start: go to CLR, clr_addr=0. clear_start wins over a simultaneous s_valid, which is not accepted.
    - Else on accept: latch bin, go to RD.
  - RD: ram_address=bin, ram_wren=0. Go to CAP.
  - CAP: ram_q holds RAM[bin]. Register nxt=ram_q+1, width DATA_W. Go to WR.
  - WR: ram_address=bin, ram_data=nxt, ram_wren=1. sample_count increments, saturating at 0xFFFFFFFF. Go to IDLE.
  - CLR:
    - ram_address=clr_addr, ram_data=0, ram_wren=1, clear_busy=1.
    - clr_addr increments each cycle. After writing 2^ADDR_W-1, go to IDLE.
    - Duration is exactly 2^ADDR_W cycles.
    - sample_count and sat_flag clear on entering CLR.
- clear_start outside IDLE is ignored; it is not queued.
- Back-to-back samples to the same bin are exact, because each write completes before the next read. No forwarding is needed.
- ram_address, ram_data and ram_wren are registered per state. ram_wren is 0 in IDLE, RD and CAP.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. An in-flight sample is discarded without a write. A clear sweep is abandoned, leaving the RAM partially cleared.

Optional Feature:
- Macro: HIST_SAT_EN
- Defined:
  - If ram_q == all-ones in CAP, nxt = all-ones (saturate) and sat_flag is set.
  - sat_flag stays set until clear or reset.
- Undefined:
  - nxt = ram_q+1 modulo 2^DATA_W (all-ones wraps to 0).
  - sat_flag is tied to 0.

Test Plan:
- Reset, then clear_start pulse -> clear_busy=1 for 4096 cycles; ram_wren=1 each cycle; addresses 0..0xFFF in order; data 0. Then s_ready=1 and sample_count=0.
- After clear, preload RAM[3]=7, send s_data=0x0035 -> RD/WR address 3, ram_data=8 on the single ram_wren cycle. s_ready returns 4 cycles after accept; sample_count=1.
- After clear, send 0x0030 then 0x003F with s_valid held -> RAM[3]=2, sample_count=2, no lost update.
- With BIN_SHIFT=2, send 0xFFFF -> write to address 0xFFF (clamped); RAM[0xFFF] increments by 1.
- Preload RAM[5]=0xFFFFFFFF, send 0x0050:
  - With HIST_SAT_EN: write 0xFFFFFFFF, sat_flag=1.
  - Without: write 0x00000000, sat_flag=0.
- Assert ctrl_reset while in CAP (RAM[3]=7 preloaded) -> ram_wren never rises, RAM[3] stays 7, sample_count=0. s_ready=1 in the first cycle after reset is released.

Source files
------------

// File: rtl/hist_bin_updater.sv
// Histogram read-modify-write engine in front of a 1-cycle-latency single-port RAM.
// Define HIST_SAT_EN to make bins saturate at all-ones and raise a sticky sat_flag.
module hist_bin_updater #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned SAMPLE_W  = 16,
  parameter int unsigned BIN_SHIFT = 4
) (
  input  logic                clock,
  input  logic                ctrl_reset,
  input  logic                clear_start,
  output logic                clear_busy,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W-1:0]   ram_data,
  output logic                ram_wren,
  input  logic [DATA_W-1:0]   ram_q,
  output logic [31:0]         sample_count,
  output logic                sat_flag
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned IDX_W = (SAMPLE_W > ADDR_W) ? SAMPLE_W : ADDR_W;
  localparam logic [ADDR_W-1:0] BIN_MAX = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] DATA_MAX = {DATA_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_CLR
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   bin_q, bin_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wren_q, wren_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sat_q, sat_d;

  logic [IDX_W-1:0]    idx_c;
  logic [ADDR_W-1:0]   bin_c;

  // Bin index from the raw sample, clamped to the top bin instead of wrapping
  assign idx_c = IDX_W'(s_data >> BIN_SHIFT);
  assign bin_c = (idx_c > IDX_W'(BIN_MAX)) ? BIN_MAX : ADDR_W'(idx_c);

  assign s_ready      = (state_q == ST_IDLE) & ~clear_start;
  assign ram_address  = addr_q;
  assign ram_data     = data_q;
  assign ram_wren     = wren_q;
  assign clear_busy   = busy_q;
  assign sample_count = cnt_q;
  assign sat_flag     = sat_q;

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // RAM-side outputs are computed for the state being entered, so they are valid during it
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    busy_d  = 1'b0;
    cnt_d   = cnt_q;
    sat_d   = sat_q;

    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLR;
          addr_d  = '0;
          data_d  = '0;
          wren_d  = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end else if (s_valid) begin
          state_d = ST_RD;
          bin_d   = bin_c;
          addr_d  = bin_c;
        end
      end
      ST_RD: begin
        state_d = ST_CAP;
      end
      ST_CAP: begin
        state_d = ST_WR;
        addr_d  = bin_q;
        wren_d  = 1'b1;
`ifdef HIST_SAT_EN
        if (ram_q == DATA_MAX) begin
          data_d = DATA_MAX;
          sat_d  = 1'b1;
        end else begin
          data_d = ram_q + DATA_W'(1);
        end
`else
        data_d = ram_q + DATA_W'(1);
`endif
      end
      ST_WR: begin
        state_d = ST_IDLE;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CLR: begin
        data_d = '0;
        if (addr_q == BIN_MAX) begin
          state_d = ST_IDLE;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          wren_d = 1'b1;
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hist_bin_updater.sv
// Self-checking bench for hist_bin_updater: RAM models, write scoreboard, vector table.
module tb_hist_bin_updater;

  logic        clk;
  logic        ctrl_reset;
  logic        clear_start;
  logic        s_valid;
  logic [15:0] s_data;

  logic        busy0, ready0, wren0, sat0;
  logic [11:0] addr0;
  logic [31:0] data0, q0, cnt0;
  logic        busy1, ready1, wren1, sat1;
  logic [11:0] addr1;
  logic [31:0] data1, q1, cnt1;

  logic [31:0] mem0 [4096];
  logic [31:0] mem1 [4096];
  logic        pre_en;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t sbq[$];

  typedef struct {
    logic [15:0] s;
    logic [31:0] pre;
    logic [11:0] ea;
    logic [31:0] ed;
  } vec_t;
  vec_t vecs[7];

`ifdef HIST_SAT_EN
  localparam logic [31:0] SAT_DATA = 32'hFFFF_FFFF;
  localparam logic [31:0] SAT_FLAG = 32'd1;
`else
  localparam logic [31:0] SAT_DATA = 32'h0000_0000;
  localparam logic [31:0] SAT_FLAG = 32'd0;
`endif

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  logic [11:0] l1_addr;
  logic [31:0] l1_data;

  hist_bin_updater #(.ADDR_W(12), .DATA_W(32), .SAMPLE_W(16), .BIN_SHIFT(4)) dut0 (
    .clock(clk), .ctrl_reset(ctrl_reset), .clear_start(clear_start), .clear_busy(busy0),
    .s_valid(s_valid), .s_ready(ready0), .s_data(s_data),
    .ram_address(addr0), .ram_data(data0), .ram_wren(wren0), .ram_q(q0),
    .sample_count(cnt0), .sat_flag(sat0)
  );

  hist_bin_updater #(.ADDR_W(12), .DATA_W(32), .SAMPLE_W(16), .BIN_SHIFT(2)) dut1 (
    .clock(clk), .ctrl_reset(ctrl_reset), .clear_start(clear_start), .clear_busy(busy1),
    .s_valid(s_valid), .s_ready(ready1), .s_data(s_data),
    .ram_address(addr1), .ram_data(data1), .ram_wren(wren1), .ram_q(q1),
    .sample_count(cnt1), .sat_flag(sat1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAMs, read data one cycle after the address; preload port for dut0's RAM
  always @(posedge clk) begin
    if (pre_en) mem0[pre_addr] <= pre_data;
    else if (wren0) mem0[addr0] <= data0;
    q0 <= mem0[addr0];
    if (wren1) mem1[addr1] <= data1;
    q1 <= mem1[addr1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and score any sample write seen there
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (!ctrl_reset && wren1 && !busy1) begin
      l1_addr = addr1;
      l1_data = data1;
    end
    if (!ctrl_reset && wren0 && !busy0) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h expected no write", addr0, data0);
      end else begin
        e = sbq.pop_front();
        if (addr0 !== e.addr || data0 !== e.data) begin
          bad++;
          $display("FAIL sb_write: got addr=%h data=%h expected addr=%h data=%h",
                   addr0, data0, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] v);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_addr = a; pre_data = v;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, output int lat);
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = d;
    @(posedge clk); #1;
    s_valid = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!ready0 && lat < 20);
  endtask

  task automatic do_clear(input bit with_sample);
    int errs;
    @(posedge clk); #1;
    clear_start = 1'b1;
    if (with_sample) begin
      s_valid = 1'b1; s_data = 16'h0035;
    end
    @(posedge clk); #1;
    clear_start = 1'b0; s_valid = 1'b0;
    errs = 0;
    for (int i = 0; i < 4096; i++) begin
      tick();
      if (!(busy0 === 1'b1 && wren0 === 1'b1 && addr0 === 12'(i) && data0 === 32'd0 && ready0 === 1'b0))
        errs++;
    end
    chk("clear_sweep_errs", 32'(errs), 32'd0);
    tick();
    chk("clear_done_busy", 32'(busy0), 32'd0);
    chk("clear_done_wren", 32'(wren0), 32'd0);
    chk("clear_done_ready", 32'(ready0), 32'd1);
    chk("clear_done_count", cnt0, 32'd0);
    chk("clear_done_sat", 32'(sat0), 32'd0);
    exp_cnt = 0;
  endtask

  initial begin
    int   lat;
    logic busy_seen, wr_seen;
    logic [31:0] before1, v0;

    vecs[0] = '{s: 16'h0035, pre: 32'd7,          ea: 12'h003, ed: 32'd8};
    vecs[1] = '{s: 16'h0000, pre: 32'd0,          ea: 12'h000, ed: 32'd1};
    vecs[2] = '{s: 16'h1234, pre: 32'd99,         ea: 12'h123, ed: 32'd100};
    vecs[3] = '{s: 16'hFFFF, pre: 32'h10,         ea: 12'hFFF, ed: 32'h11};
    vecs[4] = '{s: 16'h0050, pre: 32'hFFFF_FFFF,  ea: 12'h005, ed: SAT_DATA};
    vecs[5] = '{s: 16'h000F, pre: 32'd5,          ea: 12'h000, ed: 32'd6};
    vecs[6] = '{s: 16'h8001, pre: 32'h7FFF_FFFF,  ea: 12'h800, ed: 32'h8000_0000};

    ctrl_reset = 1'b1; clear_start = 1'b0; s_valid = 1'b0; s_data = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    l1_addr = '0; l1_data = '0;
    #1;
    chk("rst_addr", 32'(addr0), 32'd0);
    chk("rst_data", data0, 32'd0);
    chk("rst_wren", 32'(wren0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_count", cnt0, 32'd0);
    chk("rst_sat", 32'(sat0), 32'd0);
    repeat (3) @(negedge clk);
    ctrl_reset = 1'b0;
    tick();
    chk("rst_ready", 32'(ready0), 32'd1);

    do_clear(1'b0);

    // Table of single samples with preloaded bins
    foreach (vecs[i]) begin
      preload(vecs[i].ea, vecs[i].pre);
      sbq.push_back('{addr: vecs[i].ea, data: vecs[i].ed});
      send(vecs[i].s, lat);
      exp_cnt++;
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_ram", i), mem0[vecs[i].ea], vecs[i].ed);
      chk($sformatf("vec%0d_count", i), cnt0, 32'(exp_cnt));
    end
    chk("sat_sticky", 32'(sat0), SAT_FLAG);

    // Clamp with BIN_SHIFT=2: 0xFFFF >> 2 exceeds the top bin
    before1 = mem1[12'hFFF];
    v0 = mem0[12'hFFF] + 32'd1;
    sbq.push_back('{addr: 12'hFFF, data: v0});
    send(16'hFFFF, lat);
    exp_cnt++;
    chk("clamp_addr", 32'(l1_addr), 32'hFFF);
    chk("clamp_data", l1_data, before1 + 32'd1);
    chk("clamp_ram", mem1[12'hFFF], before1 + 32'd1);
    chk("clamp_count1", cnt1, 32'(exp_cnt));
    chk("clamp_sat1", 32'(sat1), 32'd0);
    chk("clamp_ready1", 32'(ready1), 32'd1);

    // clear_start together with s_valid: the clear wins, sample dropped
    do_clear(1'b1);

    // Back-to-back samples to bin 3 with s_valid held
    sbq.push_back('{addr: 12'h003, data: 32'd1});
    sbq.push_back('{addr: 12'h003, data: 32'd2});
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 16'h0030;
    @(posedge clk); #1;
    s_data = 16'h003F;
    lat = 0;
    do begin tick(); lat++; end while (!ready0 && lat < 20);
    chk("b2b_lat1", 32'(lat), 32'd4);
    @(posedge clk); #1;
    s_valid = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (!ready0 && lat < 20);
    chk("b2b_lat2", 32'(lat), 32'd4);
    chk("b2b_ram", mem0[3], 32'd2);
    chk("b2b_count", cnt0, 32'd2);

    // clear_start while busy with a sample is ignored
    sbq.push_back('{addr: 12'h003, data: 32'd3});
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 16'h0035;
    @(posedge clk); #1;
    s_valid = 1'b0; clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    busy_seen = 1'b0;
    repeat (3) begin tick(); busy_seen |= busy0; end
    chk("ign_clear_busy", 32'(busy_seen), 32'd0);
    chk("ign_clear_ready", 32'(ready0), 32'd1);
    chk("ign_clear_count", cnt0, 32'd3);

    // Reset landing in CAP discards the sample
    preload(12'h003, 32'd7);
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 16'h0035;
    @(posedge clk); #1;
    s_valid = 1'b0;
    tick();
    @(posedge clk); #1;
    ctrl_reset = 1'b1;
    #1;
    wr_seen = wren0;
    chk("midrst_addr", 32'(addr0), 32'd0);
    tick();
    tick();
    ctrl_reset = 1'b0;
    tick();
    chk("midrst_ready", 32'(ready0), 32'd1);
    repeat (6) begin tick(); wr_seen |= wren0; end
    chk("midrst_wren", 32'(wr_seen), 32'd0);
    chk("midrst_ram", mem0[3], 32'd7);
    chk("midrst_count", cnt0, 32'd0);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
